// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file and interrupt/trap unit for the
// 3-stage RV32I pipeline (execute/writeback stage).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   inst_valid              stage holds a real instruction (not a bubble)
//   csr_rd/csr_wr/is_mret   decoder strobes
//   csr_addr, csr_wdata     CSR address and write data (rs1)
//   pc_i                    PC of the instruction in this stage
//   timer_irq, ext_irq      level interrupt requests
//   csr_rdata               combinational read data to the writeback mux
//   epc_taken, epc_out      redirect/flush pulse and target PC
//
// Optional feature: define CSR_MCYCLE_EN to add the 64-bit mcycle/mcycleh
// counter at 0xB00/0xB80. Without it, both addresses read 0 and ignore writes.
module csr_file #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  MTVEC_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic             csr_rd,
    input  logic             csr_wr,
    input  logic             is_mret,
    input  logic [11:0]      csr_addr,
    input  logic [XLEN-1:0]  csr_wdata,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             timer_irq,
    input  logic             ext_irq,
    output logic [XLEN-1:0]  csr_rdata,
    output logic             epc_taken,
    output logic [XLEN-1:0]  epc_out
);

    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMie     = 12'h304;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [11:0] AddrMip     = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] AddrMcycle  = 12'hB00;
    localparam logic [11:0] AddrMcycleh = 12'hB80;
`endif

    logic              mstatus_mie_q;
    logic              mstatus_mpie_q;
    logic              mtie_q;
    logic              meie_q;
    logic              mtip_q;
    logic              meip_q;
    logic [XLEN-1:2]   mtvec_base_q;
    logic              mtvec_mode_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
`ifdef CSR_MCYCLE_EN
    logic [63:0]       mcycle_q;
`endif

    logic              ext_pend;
    logic              tim_pend;
    logic              irq_take;
    logic              mret_take;
    logic              wr_en;
    logic [4:0]        cause_code;
    logic [XLEN-1:0]   trap_target;
    logic [XLEN-1:0]   rdata_sel;

    always_comb begin
        ext_pend   = meie_q & meip_q;
        tim_pend   = mtie_q & mtip_q;
        irq_take   = inst_valid & mstatus_mie_q & ~is_mret & (ext_pend | tim_pend);
        cause_code = ext_pend ? 5'd11 : 5'd7;
        mret_take  = inst_valid & is_mret;
        // A trap or mret in the same slot swallows the write.
        wr_en      = inst_valid & csr_wr & ~irq_take & ~mret_take;
        trap_target = {mtvec_base_q, 2'b00};
        if (mtvec_mode_q) begin
            trap_target = trap_target + XLEN'({cause_code, 2'b00});
        end
    end

    always_comb begin
        epc_taken = irq_take | mret_take;
        epc_out   = '0;
        if (irq_take) begin
            epc_out = trap_target;
        end else if (mret_take) begin
            epc_out = mepc_q;
        end
    end

    always_comb begin
        rdata_sel = '0;
        case (csr_addr)
            AddrMstatus: begin
                rdata_sel[3] = mstatus_mie_q;
                rdata_sel[7] = mstatus_mpie_q;
            end
            AddrMie: begin
                rdata_sel[7]  = mtie_q;
                rdata_sel[11] = meie_q;
            end
            AddrMtvec:   rdata_sel = {mtvec_base_q, 1'b0, mtvec_mode_q};
            AddrMepc:    rdata_sel = mepc_q;
            AddrMcause:  rdata_sel = mcause_q;
            AddrMip: begin
                rdata_sel[7]  = mtip_q;
                rdata_sel[11] = meip_q;
            end
`ifdef CSR_MCYCLE_EN
            AddrMcycle:  rdata_sel = mcycle_q[31:0];
            AddrMcycleh: rdata_sel = mcycle_q[63:32];
`endif
            default:     rdata_sel = '0;
        endcase
        csr_rdata = csr_rd ? rdata_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtie_q         <= 1'b0;
            meie_q         <= 1'b0;
            mtip_q         <= 1'b0;
            meip_q         <= 1'b0;
            mtvec_base_q   <= MTVEC_RST[XLEN-1:2];
            mtvec_mode_q   <= MTVEC_RST[0];
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            // mip tracks the request lines regardless of bubbles.
            mtip_q <= timer_irq;
            meip_q <= ext_irq;
            if (irq_take) begin
                mepc_q         <= pc_i;
                mcause_q       <= {1'b1, {(XLEN-6){1'b0}}, cause_code};
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (wr_en) begin
                case (csr_addr)
                    AddrMstatus: begin
                        mstatus_mie_q  <= csr_wdata[3];
                        mstatus_mpie_q <= csr_wdata[7];
                    end
                    AddrMie: begin
                        mtie_q <= csr_wdata[7];
                        meie_q <= csr_wdata[11];
                    end
                    AddrMtvec: begin
                        mtvec_base_q <= csr_wdata[XLEN-1:2];
                        mtvec_mode_q <= csr_wdata[0];
                    end
                    AddrMepc:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    AddrMcause: mcause_q <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle_q <= '0;
        end else if (wr_en && csr_addr == AddrMcycle) begin
            mcycle_q <= {mcycle_q[63:32], csr_wdata[31:0]};
        end else if (wr_en && csr_addr == AddrMcycleh) begin
            mcycle_q <= {csr_wdata[31:0], mcycle_q[31:0]};
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

    localparam logic [31:0] TbMtvecRst = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, csr_rd, csr_wr, is_mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, pc_i;
    logic        timer_irq, ext_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural CSR values as software sees them.
    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cycle;

    logic [31:0] obs_rdata, obs_out;
    logic        obs_taken;

    always #5 clk = ~clk;

    csr_file #(
        .XLEN      (32),
        .MTVEC_RST (TbMtvecRst)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .csr_rd     (csr_rd),
        .csr_wr     (csr_wr),
        .is_mret    (is_mret),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .pc_i       (pc_i),
        .timer_irq  (timer_irq),
        .ext_irq    (ext_irq),
        .csr_rdata  (csr_rdata),
        .epc_taken  (epc_taken),
        .epc_out    (epc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: m_mstatus = d & 32'h0000_0088;
            12'h304: m_mie     = d & 32'h0000_0880;
            12'h305: m_mtvec   = d & ~32'h2;
            12'h341: m_mepc    = d & ~32'h3;
            12'h342: m_mcause  = d;
            default: ;
        endcase
    endtask

    // One instruction slot: drive, check combinational outputs, then advance
    // the model across the clock edge.
    task automatic step(input logic rst, input logic valid, input logic rd, input logic wr,
                        input logic mret, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] pc, input logic tirq, input logic eirq,
                        input logic chk);
        logic [31:0] pend, target, exp_out;
        logic        take, ret;
        int          cause;
        @(negedge clk);
        rst_n = rst; inst_valid = valid; csr_rd = rd; csr_wr = wr; is_mret = mret;
        csr_addr = a; csr_wdata = d; pc_i = pc; timer_irq = tirq; ext_irq = eirq;
        pend   = m_mie & m_mip;
        take   = valid && m_mstatus[3] && !mret && (pend != 0);
        ret    = valid && mret;
        cause  = pend[11] ? 11 : 7;
        target = (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'(4 * cause) : 32'h0);
        exp_out = take ? target : (ret ? m_mepc : 32'h0);
        #1;
        obs_rdata = csr_rdata; obs_taken = epc_taken; obs_out = epc_out;
        if (chk) begin
            check("rdata", obs_rdata, rd ? m_read(a) : 32'h0);
            check("epc_taken", {31'b0, obs_taken}, {31'b0, take || ret});
            check("epc_out", obs_out, exp_out);
        end
        @(posedge clk);
        if (!rst) begin
            m_mstatus = 0; m_mie = 0; m_mip = 0; m_mepc = 0; m_mcause = 0;
            m_mtvec = TbMtvecRst & ~32'h2;
            m_cycle = 0;
        end else begin
            if (valid && wr && !take && !ret && (a == 12'hB00))
                m_cycle = {m_cycle[63:32], d};
            else if (valid && wr && !take && !ret && (a == 12'hB80))
                m_cycle = {d, m_cycle[31:0]};
            else
                m_cycle = m_cycle + 1;
            if (take) begin
                m_mepc    = pc;
                m_mcause  = 32'h8000_0000 + 32'(cause);
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (ret) begin
                m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (valid && wr) begin
                m_write(a, d);
            end
            m_mip = (eirq ? 32'h800 : 32'h0) | (tirq ? 32'h80 : 32'h0);
        end
    endtask

    task automatic rd_csr(input logic [11:0] a, input logic tirq, input logic eirq);
        step(1, 1, 1, 0, 0, a, 32'h0, 32'h0, tirq, eirq, 1);
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        step(1, 1, 0, 1, 0, a, d, 32'h0, 0, 0, 1);
    endtask

    logic [11:0] addr_list [12] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                    12'h300, 12'h304, 12'hB00, 12'hB80, 12'h000, 12'h7C0};

    initial begin
        logic tirq, eirq;
        rst_n = 0; inst_valid = 0; csr_rd = 0; csr_wr = 0; is_mret = 0;
        csr_addr = 0; csr_wdata = 0; pc_i = 0; timer_irq = 0; ext_irq = 0;
        m_mstatus = 0; m_mie = 0; m_mip = 0; m_mepc = 0; m_mcause = 0; m_mtvec = 0; m_cycle = 0;

        // Reset held against pending interrupt and write.
        step(0, 1, 0, 1, 0, 12'h305, 32'hFFFF_FFFF, 32'h0, 0, 1, 0);
        step(0, 1, 0, 1, 0, 12'h305, 32'hFFFF_FFFF, 32'h0, 0, 1, 1);
        check("reset_taken", {31'b0, obs_taken}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            rd_csr(addr_list[i], 0, 0);
            check("reset_val", obs_rdata, (addr_list[i] == 12'h305) ? TbMtvecRst : 32'h0);
        end

        // Write/read and masking.
        wr_csr(12'h305, 32'h0000_0101);
        rd_csr(12'h305, 0, 0);
        check("mtvec_rw", obs_rdata, 32'h0000_0101);
        wr_csr(12'h300, 32'hFFFF_FFFF);
        rd_csr(12'h300, 0, 0);
        check("mstatus_mask", obs_rdata, 32'h0000_0088);

        // Vectored timer interrupt.
        wr_csr(12'h304, 32'h0000_0080);
        step(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h44, 1, 0, 1);
        check("irq_latency", {31'b0, obs_taken}, 32'h0);
        step(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h44, 1, 0, 1);
        check("timer_taken", {31'b0, obs_taken}, 32'h1);
        check("timer_target", obs_out, 32'h0000_011C);
        rd_csr(12'h341, 1, 0);
        check("timer_mepc", obs_rdata, 32'h44);
        check("no_reentry", {31'b0, obs_taken}, 32'h0);
        rd_csr(12'h342, 0, 0);
        check("timer_mcause", obs_rdata, 32'h8000_0007);
        rd_csr(12'h300, 0, 0);
        check("timer_mstatus", obs_rdata, 32'h0000_0080);

        // mret, then mret in a bubble.
        step(1, 1, 0, 0, 1, 12'h0, 32'h0, 32'h90, 0, 0, 1);
        check("mret_taken", {31'b0, obs_taken}, 32'h1);
        check("mret_target", obs_out, 32'h44);
        rd_csr(12'h300, 0, 0);
        check("mret_mstatus", obs_rdata, 32'h0000_0088);
        step(1, 0, 0, 0, 1, 12'h0, 32'h0, 32'h90, 0, 0, 1);
        check("bubble_mret", {31'b0, obs_taken}, 32'h0);

        // External beats timer; a write in the take cycle is dropped.
        wr_csr(12'h304, 32'h0000_0880);
        step(1, 1, 0, 0, 0, 12'h0, 32'h0, 32'h48, 1, 1, 1);
        step(1, 1, 0, 1, 0, 12'h304, 32'h0, 32'h48, 1, 1, 1);
        check("ext_taken", {31'b0, obs_taken}, 32'h1);
        check("ext_target", obs_out, 32'h0000_012C);
        rd_csr(12'h342, 0, 0);
        check("ext_mcause", obs_rdata, 32'h8000_000B);
        rd_csr(12'h304, 0, 0);
        check("wr_suppressed", obs_rdata, 32'h0000_0880);

        // Randomized traffic against the model.
        tirq = 0; eirq = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] a;
            logic [31:0] d;
            if ($urandom_range(7) == 0) tirq = ~tirq;
            if ($urandom_range(7) == 0) eirq = ~eirq;
            a = addr_list[$urandom_range(11)];
            d = $urandom;
            step($urandom_range(199) != 0, $urandom_range(5) != 0, $urandom_range(1) == 1,
                 $urandom_range(2) == 0, $urandom_range(9) == 0, a, d,
                 $urandom & ~32'h3, tirq, eirq, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
